// File: rtl/sync_filter_bank_pkg.sv
// rtl/sync_filter_bank_pkg.sv - shared CDC constants and helpers for the synchroniser bank
package sync_filter_bank_pkg;

  // Legal synchroniser depth range
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  // Stability counter width: enough to hold 0..stable, never narrower than one bit
  function automatic int cnt_width(input int stable);
    int w;
    w = $clog2(stable + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // True when a requested synchroniser depth is within the legal range
  function automatic bit stages_ok(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// rtl/sync_filter_chan.sv - one channel: sync chain, stability filter and edge pulses
module sync_filter_chan
  import sync_filter_bank_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int STABLE = 4
) (
  input  logic         syn_clk,
  input  logic         rst,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] syn_out_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o,
  output logic         chg_o,
  output logic         chg_next_o
);

  // In bypass the syn_out register itself is the last synchroniser stage,
  // so the explicit chain is one flop shorter and total latency stays STAGES.
  localparam int CHAIN = (STABLE == 0) ? STAGES - 1 : STAGES;

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("sync_filter_chan: STAGES out of range");
  end

  logic [W-1:0] sync_q [CHAIN];
  logic [W-1:0] tail;
  logic [W-1:0] syn_out_q;
  logic [W-1:0] syn_d;
  logic [W-1:0] rise_q;
  logic [W-1:0] rise_d;
  logic [W-1:0] fall_q;
  logic [W-1:0] fall_d;
  logic         chg_q;
  logic         chg_d;

  // Plain flop chain, no logic between stages
  always_ff @(posedge syn_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHAIN; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= din_i;
      for (int i = 1; i < CHAIN; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign tail = sync_q[CHAIN-1];

  if (STABLE > 0) begin : g_filter
    localparam int            CW       = cnt_width(STABLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [W-1:0]  cand_q;
    logic [W-1:0]  cand_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Candidate tracking: a new tail value restarts the count; a candidate that
    // differs from syn_out is accepted once it has survived STABLE more edges.
    always_comb begin
      cand_d = cand_q;
      cnt_d  = '0;
      syn_d  = syn_out_q;
      if (tail != cand_q) begin
        cand_d = tail;
      end else if (cand_q != syn_out_q) begin
        if (cnt_q == CNT_LAST) begin
          syn_d = cand_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Candidate and counter registers
    always_ff @(posedge syn_clk or posedge rst) begin
      if (rst) begin
        cand_q <= '0;
        cnt_q  <= '0;
      end else begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
      end
    end
  end else begin : g_bypass
    assign syn_d = tail;
  end

  // Pulses are derived from the next and current level so they line up with the update
  always_comb begin
    rise_d = syn_d & ~syn_out_q;
    fall_d = ~syn_d & syn_out_q;
    chg_d  = |(syn_d ^ syn_out_q);
  end

  // Output level and registered one-cycle events
  always_ff @(posedge syn_clk or posedge rst) begin
    if (rst) begin
      syn_out_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      chg_q     <= 1'b0;
    end else begin
      syn_out_q <= syn_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      chg_q     <= chg_d;
    end
  end

  assign syn_out_o  = syn_out_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign chg_o      = chg_q;
  assign chg_next_o = chg_d;

endmodule

// File: rtl/sync_filter_bank.sv
// rtl/sync_filter_bank.sv - multi-channel synchroniser with stability filter and change events
module sync_filter_bank
  import sync_filter_bank_pkg::*;
#(
  parameter int W      = 8,
  parameter int CH     = 4,
  parameter int STAGES = 2,
  parameter int STABLE = 4
) (
  input  logic          syn_clk,
  input  logic          rst,
  input  logic [CH*W-1:0] in,
  output logic [CH*W-1:0] syn_out,
  output logic [CH*W-1:0] rise,
  output logic [CH*W-1:0] fall,
  output logic [CH-1:0]   chg_pulse,
  output logic            any_chg
);

  logic [CH-1:0] chg_next;
  logic          any_chg_q;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    sync_filter_chan #(
      .W      (W),
      .STAGES (STAGES),
      .STABLE (STABLE)
    ) u_chan (
      .syn_clk    (syn_clk),
      .rst        (rst),
      .din_i      (in[c*W +: W]),
      .syn_out_o  (syn_out[c*W +: W]),
      .rise_o     (rise[c*W +: W]),
      .fall_o     (fall[c*W +: W]),
      .chg_o      (chg_pulse[c]),
      .chg_next_o (chg_next[c])
    );
  end

  // any_chg is registered from the per-channel next-change terms so it aligns with chg_pulse
  always_ff @(posedge syn_clk or posedge rst) begin
    if (rst) begin
      any_chg_q <= 1'b0;
    end else begin
      any_chg_q <= |chg_next;
    end
  end

  assign any_chg = any_chg_q;

endmodule
